// File: rtl/irq_scheduler.sv
// Machine-level interrupt scheduler: owns mtime/mtimecmp, latches external edges, arbitrates and sequences one interrupt at a time.
// Latency: interrupt code registered one edge after its condition; backpressure: the code is held in REQ until taken or withdrawn.
module irq_scheduler #(
    parameter int N_EXT = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    input  logic [N_EXT-1:0] ext_irq,
    input  logic             irq_taken,
    input  logic             is_mret,
    output logic [3:0]       interrupt,
    output logic [ID_W-1:0]  ext_id,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state, state_nx;
    logic [31:0]      mtime, mtimecmp;
    logic [N_EXT-1:0] ext_en, ext_pend, ext_irq_q;
    logic [N_EXT-1:0] rise, w1c, take_clr, id_mask;
    logic [3:0]       int_nx;
    logic [ID_W-1:0]  id_nx, low_id;
    logic             timer_pend, withdraw;

    assign timer_pend = (mtime >= mtimecmp);
    assign rise       = ext_irq & ~ext_irq_q & ext_en;
    assign w1c        = (cfg_we && cfg_addr == 2'd3) ? cfg_wdata[N_EXT-1:0] : '0;

    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_addr)
            2'd0:    cfg_rdata = mtimecmp;
            2'd1:    cfg_rdata = mtime;
            2'd2:    cfg_rdata = {{(32-N_EXT){1'b0}}, ext_en};
            default: cfg_rdata = {{(32-N_EXT){1'b0}}, ext_pend};
        endcase
    end

    // One-hot of the claimed source and lowest-index pending source.
    always_comb begin
        id_mask = '0;
        low_id  = '0;
        for (int i = 0; i < N_EXT; i++) begin
            id_mask[i] = (ext_id == ID_W'(i));
        end
        for (int i = N_EXT - 1; i >= 0; i--) begin
            if (ext_pend[i]) low_id = ID_W'(i);
        end
    end

    assign withdraw = (interrupt == 4'd1 && !timer_pend) ||
                      (interrupt == 4'd2 && !(|(ext_pend & id_mask)));

    always_comb begin
        state_nx = state;
        int_nx   = interrupt;
        id_nx    = ext_id;
        take_clr = '0;
        case (state)
            IDLE: begin
                if (timer_pend) begin
                    state_nx = REQ;
                    int_nx   = 4'd1;
                end else if (|ext_pend) begin
                    state_nx = REQ;
                    int_nx   = 4'd2;
                    id_nx    = low_id;
                end else begin
                    int_nx   = 4'd0;
                end
            end
            REQ: begin
                // Taking wins over a same-cycle withdraw.
                if (irq_taken) begin
                    state_nx = SERVICE;
                    int_nx   = 4'd0;
                    if (interrupt == 4'd2) take_clr = id_mask;
                end else if (withdraw) begin
                    state_nx = IDLE;
                    int_nx   = 4'd0;
                end
            end
            SERVICE: begin
                int_nx = 4'd0;
                if (is_mret) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                int_nx   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime     <= 32'd0;
            mtimecmp  <= 32'hFFFF_FFFF;
            ext_en    <= '0;
            ext_pend  <= '0;
            ext_irq_q <= '0;
            state     <= IDLE;
            interrupt <= 4'd0;
            ext_id    <= '0;
            busy      <= 1'b0;
        end else begin
            mtime     <= (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : mtime + 32'd1;
            if (cfg_we && cfg_addr == 2'd0) mtimecmp <= cfg_wdata;
            if (cfg_we && cfg_addr == 2'd2) ext_en <= cfg_wdata[N_EXT-1:0];
            // New rising edges beat both the take-clear and the software clear.
            ext_pend  <= (ext_pend & ~w1c & ~take_clr) | rise;
            ext_irq_q <= ext_irq;
            state     <= state_nx;
            interrupt <= int_nx;
            ext_id    <= id_nx;
            busy      <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_irq_scheduler.sv
// Bench for irq_scheduler: directed scenarios with fixed expectations plus a randomized run against a behavioural model.
module tb_irq_scheduler;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_addr = 2'd0;
    logic [31:0]   cfg_wdata = 32'd0;
    logic [31:0]   cfg_rdata;
    logic [N-1:0]  ext_irq = '0;
    logic          irq_taken = 1'b0;
    logic          is_mret = 1'b0;
    logic [3:0]    interrupt;
    logic [1:0]    ext_id;
    logic          busy;

    int checks = 0;
    int errors = 0;

    irq_scheduler #(.N_EXT(N), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .ext_irq(ext_irq),
        .irq_taken(irq_taken), .is_mret(is_mret), .interrupt(interrupt),
        .ext_id(ext_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 = nothing outstanding, 1 = requesting, 2 = in handler.
    logic [31:0]  m_mtime, m_cmp;
    logic [N-1:0] m_en, m_pend, m_prev, m_rise, m_clr, m_w1c;
    int           m_phase, m_lock, m_id, m_lo;
    logic         m_tp;

    always @(posedge clk) begin
        if (!rst) begin
            m_mtime = 0; m_cmp = 32'hFFFF_FFFF; m_en = 0; m_pend = 0; m_prev = 0;
            m_phase = 0; m_lock = 0; m_id = 0;
        end else begin
            m_tp   = (m_mtime >= m_cmp);
            m_rise = ext_irq & ~m_prev & m_en;
            m_clr  = 0;
            m_w1c  = (cfg_we && cfg_addr == 3) ? cfg_wdata[N-1:0] : '0;
            if (m_phase == 0) begin
                m_lo = -1;
                for (int i = 0; i < N; i++) if (m_pend[i]) begin m_lo = i; break; end
                if (m_tp) begin m_phase = 1; m_lock = 1; end
                else if (m_lo >= 0) begin m_phase = 1; m_lock = 2; m_id = m_lo; end
            end else if (m_phase == 1) begin
                if (irq_taken) begin
                    m_phase = 2;
                    if (m_lock == 2) m_clr[m_id] = 1'b1;
                end else if ((m_lock == 1 && !m_tp) || (m_lock == 2 && !m_pend[m_id])) begin
                    m_phase = 0;
                end
            end else if (is_mret) begin
                m_phase = 0;
            end
            m_pend  = (m_pend & ~m_w1c & ~m_clr) | m_rise;
            m_mtime = (cfg_we && cfg_addr == 1) ? cfg_wdata : m_mtime + 1;
            if (cfg_we && cfg_addr == 0) m_cmp = cfg_wdata;
            if (cfg_we && cfg_addr == 2) m_en = cfg_wdata[N-1:0];
            m_prev = ext_irq;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        checks++;
        if (interrupt !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_out: interrupt=%0d busy=%0b required 0/0", interrupt, busy);
        end
        cfg_addr = 2'd1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k % 25 == 0) begin
                checks++;
                if (cfg_rdata !== 32'(k)) begin
                    errors++; $display("FAIL reset_mtime: mtime=%0d required %0d", cfg_rdata, k);
                end
            end
        end
        cfg_addr = 2'd0; #1;
        checks++;
        if (cfg_rdata !== 32'hFFFF_FFFF || interrupt !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_cmp: cmp=%h int=%0d busy=%0b required ffffffff/0/0", cfg_rdata, interrupt, busy);
        end
    endtask

    task automatic test_timer();
        int n;
        wr(2'd1, 32'd10);
        wr(2'd0, 32'd20);
        cfg_addr = 2'd1; #1;
        n = 0;
        while (cfg_rdata !== 32'd20 && n < 50) begin tick(); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL timer_reach: mtime=%0d required 20", cfg_rdata); end
        checks++;
        if (interrupt !== 4'd0) begin errors++; $display("FAIL timer_pre: int=%0d required 0", interrupt); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (interrupt !== 4'd1 || busy !== 1'b1) begin
                errors++; $display("FAIL timer_hold: int=%0d busy=%0b required 1/1", interrupt, busy);
            end
        end
        wr(2'd0, 32'hFFFF_FFFF);
        tick();
        checks++;
        if (interrupt !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL timer_withdraw: int=%0d busy=%0b required 0/0", interrupt, busy);
        end
    endtask

    task automatic test_ext();
        wr(2'd2, 32'hA);
        ext_irq = 4'b1011;
        tick();
        ext_irq = 4'b0000;
        cfg_addr = 2'd3; #1;
        checks++;
        if (cfg_rdata !== 32'hA || interrupt !== 4'd0) begin
            errors++; $display("FAIL ext_pend: pend=%h int=%0d required a/0", cfg_rdata, interrupt);
        end
        tick();
        checks++;
        if (interrupt !== 4'd2 || ext_id !== 2'd1) begin
            errors++; $display("FAIL ext_first: int=%0d id=%0d required 2/1", interrupt, ext_id);
        end
        irq_taken = 1'b1; tick(); irq_taken = 1'b0;
        checks++;
        if (cfg_rdata !== 32'h8 || interrupt !== 4'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL ext_taken: pend=%h int=%0d busy=%0b required 8/0/1", cfg_rdata, interrupt, busy);
        end
        is_mret = 1'b1; tick(); is_mret = 1'b0;
        tick();
        checks++;
        if (interrupt !== 4'd2 || ext_id !== 2'd3) begin
            errors++; $display("FAIL ext_second: int=%0d id=%0d required 2/3", interrupt, ext_id);
        end
        irq_taken = 1'b1; tick(); irq_taken = 1'b0;
        is_mret = 1'b1; tick(); is_mret = 1'b0;
    endtask

    task automatic test_priority();
        wr(2'd2, 32'h4);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'd0; ext_irq = 4'b0100;
        tick();
        cfg_we = 1'b0; ext_irq = 4'b0000;
        tick();
        checks++;
        if (interrupt !== 4'd1) begin errors++; $display("FAIL prio_timer: int=%0d required 1", interrupt); end
        irq_taken = 1'b1; tick(); irq_taken = 1'b0;
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'hFFFF_FFFF; is_mret = 1'b1;
        tick();
        cfg_we = 1'b0; is_mret = 1'b0;
        tick();
        checks++;
        if (interrupt !== 4'd2 || ext_id !== 2'd2) begin
            errors++; $display("FAIL prio_ext: int=%0d id=%0d required 2/2", interrupt, ext_id);
        end
        irq_taken = 1'b1; tick(); irq_taken = 1'b0;
        is_mret = 1'b1; tick(); is_mret = 1'b0;
    endtask

    task automatic test_service();
        wr(2'd2, 32'h3);
        ext_irq = 4'b0010; tick(); ext_irq = 4'b0000;
        tick();
        irq_taken = 1'b1; tick(); irq_taken = 1'b0;
        ext_irq = 4'b0001; irq_taken = 1'b1;
        tick();
        ext_irq = 4'b0000; irq_taken = 1'b0;
        cfg_addr = 2'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (interrupt !== 4'd0 || busy !== 1'b1 || cfg_rdata !== 32'h1) begin
                errors++; $display("FAIL svc_hold: int=%0d busy=%0b pend=%h required 0/1/1", interrupt, busy, cfg_rdata);
            end
        end
        is_mret = 1'b1; tick(); is_mret = 1'b0;
        tick();
        checks++;
        if (interrupt !== 4'd2 || ext_id !== 2'd0) begin
            errors++; $display("FAIL svc_after: int=%0d id=%0d required 2/0", interrupt, ext_id);
        end
        irq_taken = 1'b1; tick(); irq_taken = 1'b0;
        is_mret = 1'b1; tick(); is_mret = 1'b0;
    endtask

    task automatic test_wrap();
        wr(2'd1, 32'hFFFF_FFFE);
        wr(2'd0, 32'd1);
        tick();
        cfg_addr = 2'd1; #1;
        checks++;
        if (interrupt !== 4'd1 || cfg_rdata !== 32'd0) begin
            errors++; $display("FAIL wrap_req: int=%0d mtime=%h required 1/0", interrupt, cfg_rdata);
        end
        tick();
        checks++;
        if (interrupt !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL wrap_withdraw: int=%0d busy=%0b required 0/0", interrupt, busy);
        end
        wr(2'd0, 32'hFFFF_FFFF);
        tick(); tick();
        checks++;
        if (interrupt !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL wrap_clean: int=%0d busy=%0b required 0/0", interrupt, busy);
        end
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd1, 32'h1234);
        cfg_addr = 2'd1; #1;
        checks++;
        if (cfg_rdata !== 32'h1234) begin
            errors++; $display("FAIL wrap_write: mtime=%h required 1234", cfg_rdata);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) != 0);
            cfg_we    = ($urandom_range(0, 9) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
            if (cfg_addr == 2'd1 && $urandom_range(0, 3) == 0) cfg_wdata = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            ext_irq   = N'($urandom);
            irq_taken = ($urandom_range(0, 3) == 0);
            is_mret   = ($urandom_range(0, 4) == 0);
            tick();
            checks++;
            if (interrupt !== ((m_phase == 1) ? 4'(m_lock) : 4'd0) || busy !== (m_phase != 0)) begin
                errors++; $display("FAIL rand_out cyc %0d: int=%0d busy=%0b required %0d/%0b", c, interrupt, busy,
                                   (m_phase == 1) ? m_lock : 0, m_phase != 0);
            end
            if (m_phase != 0 && m_lock == 2) begin
                checks++;
                if (ext_id !== 2'(m_id)) begin
                    errors++; $display("FAIL rand_id cyc %0d: id=%0d required %0d", c, ext_id, m_id);
                end
            end
            checks++;
            if (cfg_rdata !== ((cfg_addr == 0) ? m_cmp : (cfg_addr == 1) ? m_mtime :
                               (cfg_addr == 2) ? 32'(m_en) : 32'(m_pend))) begin
                errors++; $display("FAIL rand_rdata cyc %0d addr %0d: got %h", c, cfg_addr, cfg_rdata);
            end
        end
        rst = 1'b1; cfg_we = 1'b0; irq_taken = 1'b0; is_mret = 1'b0; ext_irq = '0;
    endtask

    initial begin
        test_reset();
        test_timer();
        test_ext();
        test_priority();
        test_service();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
